// File: rtl/button_event_decoder_if.sv
// Button event bundle: debounced level in, single-cycle UI events out.
interface button_event_decoder_if;
  logic level;
  logic press;
  logic release_evt;
  logic click;
  logic long_press;
  logic repeat_evt;
  logic held;

  // Source side: drives the button level and observes the events.
  modport master (
    output level,
    input  press, release_evt, click, long_press, repeat_evt, held
  );

  // Decoder side: consumes the level and produces the events.
  modport slave (
    input  level,
    output press, release_evt, click, long_press, repeat_evt, held
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a clean button level into press / release / click / long-press /
// auto-repeat pulses. One hold counter is shared between the long-press
// timeout and the repeat period, because only one is active at a time.
// The release and repeat outputs are named release_evt / repeat_evt since
// "release" and "repeat" are reserved words in SystemVerilog.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int CNT_W         = 25
) (
  input  logic                       clk,
  input  logic                       reset,
  button_event_decoder_if.slave      btn
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // LOCKOUT waits for the button to be seen released, so a button held
  // through reset can never produce a spurious press.
  typedef enum logic [1:0] {
    S_LOCKOUT,
    S_IDLE,
    S_PRESSED,
    S_LONG_HELD
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             press_n, release_n, click_n, long_n, repeat_n, held_n;

  // State, counter and registered event outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_LOCKOUT;
      cnt             <= '0;
      btn.press       <= 1'b0;
      btn.release_evt <= 1'b0;
      btn.click       <= 1'b0;
      btn.long_press  <= 1'b0;
      btn.repeat_evt  <= 1'b0;
      btn.held        <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      btn.press       <= press_n;
      btn.release_evt <= release_n;
      btn.click       <= click_n;
      btn.long_press  <= long_n;
      btn.repeat_evt  <= repeat_n;
      btn.held        <= held_n;
    end
  end

  // Next-state and next-output decode; a release always wins over a
  // threshold that would fire on the same edge.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    press_n   = 1'b0;
    release_n = 1'b0;
    click_n   = 1'b0;
    long_n    = 1'b0;
    repeat_n  = 1'b0;
    held_n    = 1'b0;
    case (state)
      S_LOCKOUT: begin
        if (!btn.level) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (btn.level) begin
          state_n = S_PRESSED;
          cnt_n   = '0;
          press_n = 1'b1;
          held_n  = 1'b1;
        end
      end
      S_PRESSED: begin
        if (!btn.level) begin
          state_n   = S_IDLE;
          release_n = 1'b1;
          click_n   = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_n = S_LONG_HELD;
          cnt_n   = '0;
          long_n  = 1'b1;
          held_n  = 1'b1;
        end else begin
          cnt_n  = cnt + CNT_ONE;
          held_n = 1'b1;
        end
      end
      S_LONG_HELD: begin
        if (!btn.level) begin
          state_n   = S_IDLE;
          release_n = 1'b1;
        end else if (cnt == REPEAT_LAST) begin
          cnt_n    = '0;
          repeat_n = 1'b1;
          held_n   = 1'b1;
        end else begin
          cnt_n  = cnt + CNT_ONE;
          held_n = 1'b1;
        end
      end
      default: state_n = S_LOCKOUT;
    endcase
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed scenarios with literal
// expectations, then randomized hold/release runs checked every cycle
// against an age-based model of the press.
module tb_button_event_decoder;
  localparam int L = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  button_event_decoder_if bif ();

  button_event_decoder #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (bif)
  );

  always #5 clk = ~clk;

  // Model: a press is described only by its age in edges since acceptance.
  logic m_valid = 1'b0, m_locked = 1'b1, m_active = 1'b0;
  int   m_age = 0;
  logic e_press = 0, e_rel = 0, e_click = 0, e_long = 0, e_rep = 0, e_held = 0;

  always @(posedge clk) begin
    e_press <= 0; e_rel <= 0; e_click <= 0; e_long <= 0; e_rep <= 0; e_held <= 0;
    if (reset) begin
      m_valid <= 1; m_locked <= 1; m_active <= 0; m_age <= 0;
    end else if (m_valid) begin
      if (m_active) begin
        if (!bif.level) begin
          e_rel <= 1; e_click <= (m_age + 1 <= L); m_active <= 0;
        end else begin
          e_held <= 1;
          m_age  <= m_age + 1;
          if (m_age + 1 == L) e_long <= 1;
          if (m_age + 1 > L && ((m_age + 1 - L) % R) == 0) e_rep <= 1;
        end
      end else if (m_locked) begin
        if (!bif.level) m_locked <= 0;
      end else if (bif.level) begin
        m_active <= 1; m_age <= 0; e_press <= 1; e_held <= 1;
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("press",      int'(bif.press),       int'(e_press));
      chk("release",    int'(bif.release_evt), int'(e_rel));
      chk("click",      int'(bif.click),       int'(e_click));
      chk("long_press", int'(bif.long_press),  int'(e_long));
      chk("repeat",     int'(bif.repeat_evt),  int'(e_rep));
      chk("held",       int'(bif.held),        int'(e_held));
      chk("exclusive",  int'(bif.press) + int'(bif.long_press) + int'(bif.repeat_evt) <= 1 ? 1 : 0, 1);
    end
  end

  task automatic step(input logic l, input logic r = 1'b0);
    bif.level = l;
    reset     = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int pulses();
    return int'(bif.press) + int'(bif.release_evt) + int'(bif.click) +
           int'(bif.long_press) + int'(bif.repeat_evt);
  endfunction

  int any_out, long_at, rep_n, rep0, rep1, run;
  logic lv;

  initial begin
    // Scenario 1: button held through reset.
    bif.level = 1'b1;
    repeat (3) step(1, 1);
    chk("reset_held", int'(bif.held), 0);
    chk("reset_pulses", pulses(), 0);
    any_out = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      any_out += pulses() + int'(bif.held);
    end
    chk("locked_quiet", any_out, 0);
    step(0);
    step(1);
    chk("s1_press", int'(bif.press), 1);

    // Scenario 2: short click, then single-cycle press.
    step(0); step(0);
    step(1); chk("s2_press", int'(bif.press), 1); chk("s2_held0", int'(bif.held), 1);
    step(1); chk("s2_nopulse", int'(bif.press), 0);
    step(1); chk("s2_held2", int'(bif.held), 1);
    step(0); chk("s2_release", int'(bif.release_evt), 1); chk("s2_click", int'(bif.click), 1);
    chk("s2_held_off", int'(bif.held), 0);
    step(1); chk("s2b_press", int'(bif.press), 1);
    step(0); chk("s2b_release", int'(bif.release_evt) + int'(bif.click), 2);

    // Scenario 3: long hold with repeats.
    step(0);
    long_at = -1; rep_n = 0; rep0 = -1; rep1 = -1;
    for (int e = 0; e < 20; e++) begin
      step(1);
      if (bif.long_press) long_at = e;
      if (bif.repeat_evt) begin
        if (rep_n == 0) rep0 = e; else rep1 = e;
        rep_n++;
      end
    end
    chk("s3_long_edge", long_at, 8);
    chk("s3_rep_count", rep_n, 2);
    chk("s3_rep0", rep0, 12);
    chk("s3_rep1", rep1, 16);
    step(0); chk("s3_release", int'(bif.release_evt), 1); chk("s3_noclick", int'(bif.click), 0);

    // Scenario 4: release on the threshold edges.
    step(0);
    for (int e = 0; e < 8; e++) step(1);
    step(0);
    chk("s4_release", int'(bif.release_evt), 1);
    chk("s4_click", int'(bif.click), 1);
    chk("s4_nolong", int'(bif.long_press), 0);
    step(0);
    long_at = -1; rep_n = 0;
    for (int e = 0; e < 12; e++) begin
      step(1);
      if (bif.long_press) long_at = e;
      if (bif.repeat_evt) rep_n++;
    end
    step(0);
    chk("s4b_long_edge", long_at, 8);
    chk("s4b_release", int'(bif.release_evt), 1);
    chk("s4b_norepeat", rep_n + int'(bif.repeat_evt), 0);

    // Scenario 5: reset in the middle of a long hold.
    step(0);
    for (int e = 0; e < 10; e++) step(1);
    step(1, 1);
    chk("s5_quiet", pulses() + int'(bif.held), 0);
    any_out = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      any_out += pulses();
    end
    chk("s5_nopress", any_out, 0);
    step(0); step(1);
    chk("s5_press", int'(bif.press), 1);

    // Scenario 6: back-to-back presses.
    step(0);
    step(1); chk("s6_press0", int'(bif.press), 1);
    step(1);
    step(0); chk("s6_rel0", int'(bif.release_evt) + int'(bif.click), 2);
    step(1); chk("s6_press1", int'(bif.press), 1);
    step(1);
    step(0); chk("s6_rel1", int'(bif.release_evt) + int'(bif.click), 2);

    // Randomized runs of hold and release, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      lv  = 1'($urandom_range(0, 1));
      run = (lv && $urandom_range(0, 3) == 0) ? $urandom_range(8, 24) : $urandom_range(1, 10);
      for (int i = 0; i < run; i++)
        step(lv, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    step(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Converts the clean, debounced level of a push-button into single-cycle user-interface events: press, release, short click, long press and auto-repeat. It sits between the debounced button inputs and the RGB LED driver control logic, for example to step colour or brightness. Its input is already synchronous and bounce-free, so it does no synchronising or filtering of its own. One instance serves one button.

## Interface
- `LONG_CYCLES`, default 25000000: number of cycles the button must be held to produce `long_press`.
- `REPEAT_CYCLES`, default 5000000: period, in cycles, of `repeat` pulses after `long_press`.
- `CNT_W`, default 25: hold-counter width. Both thresholds must be ≥2 and <2^CNT_W.
- `clk`  in  1  system clock; every register is clocked on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `level`  in  1  debounced button level, already synchronous to `clk`; 1 = pressed.
- `press`  out  1  1-cycle pulse on an accepted 0→1 transition.
- `release`  out  1  1-cycle pulse on a 1→0 transition of an accepted press.
- `click`  out  1  1-cycle pulse, coincident with `release`, only when released before `long_press` fired.
- `long_press`  out  1  1-cycle pulse once per press, after `LONG_CYCLES` held.
- `repeat`  out  1  1-cycle pulse every `REPEAT_CYCLES` after `long_press` while still held.
- `held`  out  1  level output, 1 while a press is accepted and not yet released.

## Operation
- The state machine has four states: LOCKOUT, IDLE, PRESSED, LONG_HELD. There is one `CNT_W`-bit counter, `cnt`.
- **Reset:** state = LOCKOUT, `cnt` = 0, all outputs 0.
  - A button already held at reset never produces `press`.
- **LOCKOUT:**
  - `level`=0 → IDLE.
  - `level`=1 → stay. No outputs.
- **IDLE:**
  - `level`=1 → PRESSED, `cnt`=0, `press`=1.
  - `level`=0 → stay.
- **PRESSED (`held`=1):**
  - `level`=0 → IDLE, `release`=1, `click`=1.
  - Else if `cnt`==LONG_CYCLES-1 → LONG_HELD, `cnt`=0, `long_press`=1.
  - Else `cnt`+=1.
- **LONG_HELD (`held`=1):**
  - `level`=0 → IDLE, `release`=1, `click`=0.
  - Else if `cnt`==REPEAT_CYCLES-1 → `repeat`=1, `cnt`=0.
  - Else `cnt`+=1.
- **Priority when events coincide:** release beats any threshold. If `level` is sampled 0 on the edge where a threshold would fire, no `long_press` or `repeat` is emitted.
- **Counter range:** `cnt` never exceeds the active threshold minus 1, so no wrap-around or saturation logic is needed. Repeats continue indefinitely while the button is held.
- **Mutual exclusion:** `press`, `long_press` and `repeat` are never high in the same cycle. `release`/`click` never coincide with `press`.
- **Reset mid-operation:** any state → LOCKOUT on the next edge and every output drops to 0 on that same edge. No `release` is emitted for the aborted press.

## Timing
- All outputs are registered. A pulse is high for exactly the one cycle following the edge that sampled the triggering `level`.
- Edge numbering: "edge n" is the nth rising edge of `clk`; "edge 0" is the first edge at which a press is accepted (IDLE samples `level`=1).
- **Press:** `press` and `held` go high after edge 0.
- **Long press:** `long_press` is registered at edge LONG_CYCLES, provided `level` was 1 at every edge from 0 through LONG_CYCLES.
- **Repeat:** the k-th `repeat` is registered at edge LONG_CYCLES + k·REPEAT_CYCLES.
- **Release:** `release` (plus `click` if still in PRESSED) and `held`=0 are registered at the first edge sampling `level`=0.
- Back-to-back presses: after a release, `level`=1 on the very next edge produces `press` again, with no dead time.
- Throughput: one event per cycle at most.

## Test plan
All scenarios use LONG_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4.
1. **Reset with button held:** hold `level`=1 through reset and 20 cycles after → no output pulses and `held`=0. Then `level`=0 for 1 cycle and 1 again → `press` registered at the edge sampling 1.
2. **Short click:** `level`=1 at edges 0..2, 0 at edge 3 → `press` at edge 0, `release`+`click` at edge 3, `held` high after edges 0..2. Also check the single-cycle press: 1 at edge 0, 0 at edge 1 → `press` at edge 0, `release`+`click` at edge 1.
3. **Long hold with repeats:** `level`=1 at edges 0..19, 0 at edge 20 → `press` at edge 0, `long_press` at edge 8, `repeat` at edges 12 and 16, `release` at edge 20 with `click`=0.
4. **Release coincident with threshold:** `level`=1 at edges 0..7, 0 at edge 8 → `release`+`click` at edge 8, no `long_press`. Then `level`=1 at edges 0..11, 0 at edge 12 → `long_press` at edge 8, `release` at edge 12, no `repeat`.
5. **Reset mid-LONG_HELD:** assert `reset` at edge 10 of a hold with `level` still 1 → all outputs 0 from edge 10. No `press` occurs until `level` is seen 0 and then 1.
6. **Back-to-back presses:** `level` pattern 1,1,0,1,1,0 → two `press`/`release`/`click` triplets, with the second `press` on the edge immediately after the first `release`.
